// File: rtl/rv3n_muldiv_issue_pkg.sv
// Shared constants for the muldiv issue block: datapath width, op field layout, one-hot FSM encoding.
`default_nettype none

package rv3n_muldiv_issue_pkg;

    localparam int XLEN     = 32;
    localparam int PARA_W   = 8;
    localparam int IMM_W    = 13;
    localparam int PARA_DIV = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_ISSUE = 1;
    localparam int ST_WAIT  = 2;

    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_ISSUE = 3'b010;
    localparam logic [2:0] S_WAIT  = 3'b100;

    function automatic int entry_width(input int xlen, input int rd_w);
        return PARA_W + IMM_W + 3 * xlen + rd_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv3n_muldiv_issue_fifo.sv
// rv3n_md_fifo: small power-of-two FIFO with wrapping pointers, occupancy counter and flush.
`default_nettype none

module rv3n_md_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/rv3n_muldiv_issue.sv
// rv3n_muldiv_issue: queues MUL/DIV ops, issues one request at a time, turns acks into writebacks.
// Optional ack-wait watchdog enabled by defining MULDIV_TIMEOUT_EN.
`default_nettype none

module rv3n_muldiv_issue
    import rv3n_muldiv_issue_pkg::*;
#(
    parameter int XLEN    = rv3n_muldiv_issue_pkg::XLEN,
    parameter int QDEPTH  = 2,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 63
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               op_valid_i,
    output logic               op_ready_o,
    input  logic [7:0]         op_para_i,
    input  logic [12:0]        op_imm_i,
    input  logic [XLEN-1:0]    op_pc_i,
    input  logic [XLEN-1:0]    op_operand0_i,
    input  logic [XLEN-1:0]    op_operand1_i,
    input  logic [RD_W-1:0]    op_rd_i,
    input  logic               flush_i,
    output logic               req_valid_o,
    output logic [7:0]         req_para_o,
    output logic [12:0]        req_imm_o,
    output logic [XLEN-1:0]    req_pc_o,
    output logic [XLEN-1:0]    req_operand0_o,
    output logic [XLEN-1:0]    req_operand1_o,
    input  logic               ack_valid_i,
    input  logic [XLEN-1:0]    ack_data_i,
    input  logic               ack_busy_i,
    output logic               wb_valid_o,
    output logic [RD_W-1:0]    wb_rd_o,
    output logic [XLEN-1:0]    wb_data_o,
    output logic               md_pending_o,
    output logic               md_timeout_o
);

    localparam int ENTRY_W = entry_width(XLEN, RD_W);

    logic [ENTRY_W-1:0]      push_data;
    logic [ENTRY_W-1:0]      head;
    logic                    full;
    logic                    empty;
    logic [$clog2(QDEPTH):0] count;
    logic                    push;
    logic                    pop;

    logic [7:0]              head_para;
    logic [12:0]             head_imm;
    logic [XLEN-1:0]         head_pc;
    logic [XLEN-1:0]         head_op0;
    logic [XLEN-1:0]         head_op1;
    logic [RD_W-1:0]         head_rd;

    logic [2:0]              state_q, state_d;
    logic [RD_W-1:0]         inflight_rd_q, inflight_rd_d;
    logic                    drop_q, drop_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]         wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]         wb_data_q, wb_data_d;
    logic                    timeout_hit;
    logic                    freeze;

    assign push_data  = {op_para_i, op_imm_i, op_pc_i, op_operand0_i, op_operand1_i, op_rd_i};
    assign {head_para, head_imm, head_pc, head_op0, head_op1, head_rd} = head;
    assign op_ready_o = ~full;
    assign push       = op_valid_i & ~full;

    rv3n_md_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (push_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

`ifdef MULDIV_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            md_timeout_q;

    assign timeout_hit  = state_q[ST_WAIT] & ~ack_valid_i & (to_cnt_q == TO_LAST);
    assign freeze       = md_timeout_q;
    assign md_timeout_o = md_timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            if (state_q[ST_ISSUE])     to_cnt_q <= '0;
            else if (state_q[ST_WAIT]) to_cnt_q <= to_cnt_q + TO_ONE;
            if (timeout_hit)           md_timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign freeze         = 1'b0;
    assign md_timeout_o   = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        inflight_rd_d = inflight_rd_q;
        drop_d        = drop_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = '0;
        wb_data_d     = '0;
        case (state_q)
            S_IDLE: begin
                // A flush in this cycle empties the queue, so there is nothing to issue.
                if (!empty && !ack_busy_i && !freeze && !flush_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                pop           = 1'b1;
                inflight_rd_d = head_rd;
                drop_d        = flush_i;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) drop_d = 1'b1;
                if (ack_valid_i) begin
                    state_d = S_IDLE;
                    if (inflight_rd_q != '0 && !drop_q && !flush_i) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = inflight_rd_q;
                        wb_data_d  = ack_data_i;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            inflight_rd_q <= '0;
            drop_q        <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            inflight_rd_q <= inflight_rd_d;
            drop_q        <= drop_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
        end
    end

    assign req_valid_o    = state_q[ST_ISSUE];
    assign req_para_o     = state_q[ST_ISSUE] ? head_para : '0;
    assign req_imm_o      = state_q[ST_ISSUE] ? head_imm  : '0;
    assign req_pc_o       = state_q[ST_ISSUE] ? head_pc   : '0;
    assign req_operand0_o = state_q[ST_ISSUE] ? head_op0  : '0;
    assign req_operand1_o = state_q[ST_ISSUE] ? head_op1  : '0;

    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign md_pending_o = (count != '0) | ~state_q[ST_IDLE];

endmodule

`default_nettype wire

// File: tb/tb_rv3n_muldiv_issue.sv
// Directed self-checking bench for rv3n_muldiv_issue with a fixed-latency muldiv responder.
`default_nettype none

module tb_rv3n_muldiv_issue;
    import rv3n_muldiv_issue_pkg::*;

    localparam int LAT = 38;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  op_para = '0;
    logic [12:0] op_imm = '0;
    logic [31:0] op_pc = '0;
    logic [31:0] op_operand0 = '0;
    logic [31:0] op_operand1 = '0;
    logic [4:0]  op_rd = '0;
    logic        flush = 1'b0;
    logic        req_valid;
    logic [7:0]  req_para;
    logic [12:0] req_imm;
    logic [31:0] req_pc;
    logic [31:0] req_operand0;
    logic [31:0] req_operand1;
    logic        ack_valid = 1'b0;
    logic [31:0] ack_data = '0;
    logic        ack_busy = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_pending;
    logic        md_timeout;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int req_cnt = 0;
    int ack_cnt = 0;
    int busy_viol = 0;
    int dbl_viol = 0;
    int wb_zero_viol = 0;
    int min_gap = 1000;
    int last_req_cyc = -1000;
    int last_ack_cyc = 0;
    int last_wb_cyc = 0;
    logic [31:0] last_req_op0 = '0;
    logic [31:0] last_req_op1 = '0;
    logic [7:0]  last_req_para = '0;
    logic [31:0] last_ack_data = '0;
    logic        prev_req = 1'b0;
    logic        prev_busy = 1'b0;
    logic [4:0]  wbq_rd[$];
    logic [31:0] wbq_data[$];

    bit          mute = 1'b0;
    bit          r_run = 1'b0;
    int          r_cnt = 0;
    logic [31:0] r_a = '0;
    logic [31:0] r_b = '0;
    logic [7:0]  r_para = '0;

    rv3n_muldiv_issue dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .op_valid_i     (op_valid),
        .op_ready_o     (op_ready),
        .op_para_i      (op_para),
        .op_imm_i       (op_imm),
        .op_pc_i        (op_pc),
        .op_operand0_i  (op_operand0),
        .op_operand1_i  (op_operand1),
        .op_rd_i        (op_rd),
        .flush_i        (flush),
        .req_valid_o    (req_valid),
        .req_para_o     (req_para),
        .req_imm_o      (req_imm),
        .req_pc_o       (req_pc),
        .req_operand0_o (req_operand0),
        .req_operand1_o (req_operand1),
        .ack_valid_i    (ack_valid),
        .ack_data_i     (ack_data),
        .ack_busy_i     (ack_busy),
        .wb_valid_o     (wb_valid),
        .wb_rd_o        (wb_rd),
        .wb_data_o      (wb_data),
        .md_pending_o   (md_pending),
        .md_timeout_o   (md_timeout)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] md_result(input logic [7:0] p, input logic [31:0] a, input logic [31:0] b);
        if (p[PARA_DIV]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        return a * b;
    endfunction

    // Responder: latches the request, stays busy, returns the result LAT cycles later.
    always @(posedge clk) begin
        #2;
        if (ack_valid) begin
            ack_valid = 1'b0;
            ack_data  = '0;
            ack_busy  = 1'b0;
            r_run     = 1'b0;
        end else if (req_valid && !r_run) begin
            r_run    = 1'b1;
            r_cnt    = LAT;
            r_a      = req_operand0;
            r_b      = req_operand1;
            r_para   = req_para;
            ack_busy = 1'b1;
        end else if (r_run && !mute) begin
            r_cnt--;
            if (r_cnt == 0) begin
                ack_valid = 1'b1;
                ack_data  = md_result(r_para, r_a, r_b);
            end
        end
    end

    always @(negedge clk) begin
        if (req_valid) begin
            req_cnt++;
            if (prev_req)  dbl_viol++;
            if (prev_busy) busy_viol++;
            if (cyc - last_req_cyc < min_gap) min_gap = cyc - last_req_cyc;
            last_req_cyc  = cyc;
            last_req_op0  = req_operand0;
            last_req_op1  = req_operand1;
            last_req_para = req_para;
        end
        if (ack_valid) begin
            ack_cnt++;
            last_ack_cyc  = cyc;
            last_ack_data = ack_data;
        end
        if (wb_valid) begin
            wbq_rd.push_back(wb_rd);
            wbq_data.push_back(wb_data);
            last_wb_cyc = cyc;
        end else if (wb_rd != '0 || wb_data != '0) begin
            wb_zero_viol++;
        end
        prev_req  = req_valid;
        prev_busy = ack_busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic [7:0] p, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        op_para     = p;
        op_imm      = 13'h1A5;
        op_pc       = 32'h1000 + 32'(rd);
        op_operand0 = a;
        op_operand1 = b;
        op_rd       = rd;
        op_valid    = 1'b1;
        while (!op_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) chk("push_ready", op_ready, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_wb(input int n, input int limit);
        int k = 0;
        while (wbq_rd.size() < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("wb_count", wbq_rd.size(), n);
    endtask

    task automatic wait_req(input int n, input int limit);
        int k = 0;
        while (req_cnt < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("req_count_wait", req_cnt, n);
    endtask

    task automatic wait_ack(input int n, input int limit);
        int k = 0;
        while (ack_cnt < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("ack_count_wait", ack_cnt, n);
    endtask

    task automatic pop_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
        logic [4:0]  r = '0;
        logic [31:0] d = '0;
        if (wbq_rd.size() > 0) begin
            r = wbq_rd.pop_front();
            d = wbq_data.pop_front();
        end
        chk({tag, "_rd"}, r, rd);
        chk({tag, "_data"}, d, data);
    endtask

    initial begin
        int k;
        int rc;
        int a0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_md_pending", md_pending, 0);
        chk("rst_md_timeout", md_timeout, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_req_op0", req_operand0, 0);
        rst_n = 1'b1;

        // 1: single MUL, 3 * -4
        push_op(8'h00, 32'd3, 32'hFFFF_FFFC, 5'd5);
        wait_wb(1, 200);
        chk("t1_req_cnt", req_cnt, 1);
        chk("t1_req_op0", last_req_op0, 32'd3);
        chk("t1_req_op1", last_req_op1, 32'hFFFF_FFFC);
        chk("t1_req_para", last_req_para, 8'h00);
        chk("t1_wb_latency", last_wb_cyc - last_ack_cyc, 1);
        pop_wb("t1", 5'd5, 32'hFFFF_FFF4);

        // 2: three ops back-to-back into a two-entry queue
        min_gap = 1000;
        push_op(8'h00, 32'd6, 32'd7, 5'd1);
        push_op(8'h00, 32'd5, 32'd5, 5'd2);
        @(negedge clk);
        chk("t2_full_ready", op_ready, 0);
        push_op(8'h05, 32'd50, 32'd5, 5'd3);
        wait_wb(3, 400);
        pop_wb("t2a", 5'd1, 32'd42);
        pop_wb("t2b", 5'd2, 32'd25);
        pop_wb("t2c", 5'd3, 32'd10);
        chk("t2_req_cnt", req_cnt, 4);
        chk("t2_min_gap", min_gap, LAT + 2);
        chk("t2_busy_viol", busy_viol, 0);

        // 3: DIVU to x0 issues but never writes back
        a0 = ack_cnt;
        push_op(8'h05, 32'd100, 32'd7, 5'd0);
        wait_ack(a0 + 1, 200);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_req_cnt", req_cnt, 5);
        chk("t3_ack_data", last_ack_data, 32'd14);
        chk("t3_no_wb", wbq_rd.size(), 0);

        // 4: flush while waiting with one op queued
        push_op(8'h00, 32'd2, 32'd3, 5'd4);
        wait_req(6, 200);
        repeat (5) @(posedge clk);
        push_op(8'h00, 32'd7, 32'd8, 5'd6);
        @(negedge clk);
        chk("t4_pending_queued", md_pending, 1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_flush", op_ready, 1);
        k = 0;
        while (!ack_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t4_pending_at_ack", md_pending, 1);
        @(negedge clk);
        chk("t4_pending_after_ack", md_pending, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_no_wb", wbq_rd.size(), 0);
        chk("t4_flushed_not_issued", req_cnt, 6);
        push_op(8'h00, 32'd9, 32'd9, 5'd7);
        wait_wb(1, 200);
        pop_wb("t4", 5'd7, 32'd81);

        // 5: reset in the middle of WAIT
        push_op(8'h00, 32'd4, 32'd4, 5'd8);
        wait_req(8, 200);
        repeat (5) @(posedge clk);
        a0 = ack_cnt;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_pending", md_pending, 0);
        chk("t5_rst_req_valid", req_valid, 0);
        chk("t5_rst_wb_valid", wb_valid, 0);
        chk("t5_rst_op_ready", op_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_post_pending", md_pending, 0);
        wait_ack(a0 + 1, 200);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stale_ack_no_wb", wbq_rd.size(), 0);
        push_op(8'h00, 32'd11, 32'd3, 5'd9);
        wait_wb(1, 200);
        pop_wb("t5", 5'd9, 32'd33);
        chk("t5_req_cnt", req_cnt, 9);

`ifdef MULDIV_TIMEOUT_EN
        // 6: muted responder trips the watchdog
        mute = 1'b1;
        push_op(8'h00, 32'd1, 32'd1, 5'd10);
        wait_req(10, 200);
        rc = last_req_cyc;
        k = 0;
        @(negedge clk);
        while (!md_timeout && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t6_timeout_cycle", cyc - rc, 64);
        chk("t6_pending", md_pending, 0);
        push_op(8'h00, 32'd2, 32'd2, 5'd11);
        repeat (100) @(posedge clk);
        #1;
        chk("t6_frozen_req_cnt", req_cnt, 10);
        chk("t6_no_wb", wbq_rd.size(), 0);
        chk("t6_sticky", md_timeout, 1);
`else
        rc = 0;
        chk("t6_timeout_tied", md_timeout, rc);
`endif

        chk("dbl_req_viol", dbl_viol, 0);
        chk("busy_issue_viol", busy_viol, 0);
        chk("wb_idle_zero_viol", wb_zero_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
